// File: rtl/operand_loader.sv
// Packs a valid/ready word stream into a frame of (a,b) operand pairs, pulses start
// when the frame is full, and serves pairs to the datapath through a registered read port.
module operand_loader #(
  parameter int N = 16,
  parameter int K = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         flush,
  // "release" is a reserved word in SystemVerilog, hence the frm_ prefix.
  input  logic         frm_release,
  input  logic         inpRAMen,
  input  logic [K:0]   addr,
  output logic [N-1:0] a,
  output logic [N-1:0] b,
  output logic         start,
  output logic         busy,
  output logic [K+1:0] pairs_loaded,
  output logic [1:0]   dbg_state
);

  // Handshake: a word is taken at a rising edge when in_valid && in_ready and
  // flush is low; in_ready depends only on the state, never on in_valid.

  localparam int DEPTH = 2 ** (K + 1);
  localparam logic [K+1:0] WP_LAST = '1;
  localparam logic [K+1:0] ONE     = {{(K+1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_ARM  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t         r_state;
  logic [K+1:0]   r_wp;
  logic [K+1:0]   r_pairs;
  logic           r_start;
  logic           r_busy;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_b;
  logic [2*N-1:0] r_mem [DEPTH];

  logic           w_ready;
  logic           w_accept;
  logic [K:0]     w_pair;

  assign w_ready  = (r_state == S_FILL);
  assign w_accept = in_valid && w_ready && !flush;
  assign w_pair   = r_wp[K+1:1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FILL;
      r_wp    <= '0;
      r_pairs <= '0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else begin
      // Non-blocking read sees pre-write contents: read-before-write on collision.
      if (inpRAMen) begin
        r_a <= r_mem[addr][N-1:0];
        r_b <= r_mem[addr][2*N-1:N];
      end
      if (w_accept) begin
        if (r_wp[0]) r_mem[w_pair][2*N-1:N] <= in_data;
        else         r_mem[w_pair][N-1:0]   <= in_data;
      end
      r_start <= 1'b0;
      if (flush) begin
        r_state <= S_FILL;
        r_wp    <= '0;
        r_pairs <= '0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          S_FILL: begin
            if (w_accept) begin
              r_wp <= r_wp + ONE;
              if (r_wp[0]) r_pairs <= r_pairs + ONE;
              if (r_wp == WP_LAST) begin
                r_state <= S_ARM;
                r_start <= 1'b1;
                r_busy  <= 1'b1;
              end
            end
          end
          S_ARM: r_state <= S_HOLD;
          S_HOLD: begin
            if (frm_release) begin
              r_state <= S_FILL;
              r_pairs <= '0;
              r_busy  <= 1'b0;
            end
          end
          default: r_state <= S_FILL;
        endcase
      end
    end
  end

  assign in_ready     = w_ready;
  assign a            = r_a;
  assign b            = r_b;
  assign start        = r_start;
  assign busy         = r_busy;
  assign pairs_loaded = r_pairs;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_operand_loader.sv
// Directed bench for operand_loader: reference frame model plus a read scoreboard
// of expected {b,a} entries, checked one cycle after each read is issued.
module tb_operand_loader;

  localparam int N = 16;
  localparam int K = 3;

  logic          clk;
  logic          rst;
  logic [N-1:0]  in_data;
  logic          in_valid;
  logic          in_ready;
  logic          flush;
  logic          frm_release;
  logic          inpRAMen;
  logic [K:0]    addr;
  logic [N-1:0]  a;
  logic [N-1:0]  b;
  logic          start;
  logic          busy;
  logic [K+1:0]  pairs_loaded;
  logic [1:0]    dbg_state;

  operand_loader #(.N(N), .K(K)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .flush        (flush),
    .frm_release  (frm_release),
    .inpRAMen     (inpRAMen),
    .addr         (addr),
    .a            (a),
    .b            (b),
    .start        (start),
    .busy         (busy),
    .pairs_loaded (pairs_loaded),
    .dbg_state    (dbg_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int dut_acc  = 0;

  // Reference model: FILL=0, ARM=1, HOLD=2
  logic [2*N-1:0] exp_mem [16];
  logic [4:0]     exp_wp;
  logic [4:0]     exp_pairs;
  logic [1:0]     exp_state;
  logic           exp_start;
  logic           exp_busy;
  logic [2*N-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) exp_mem[i] = '0;
    exp_wp    = '0;
    exp_pairs = '0;
    exp_state = 2'd0;
    exp_start = 1'b0;
    exp_busy  = 1'b0;
    exp_q.delete();
  endtask

  task automatic chk_ctrl();
    chk("in_ready", in_ready, exp_state == 2'd0);
    chk("start", start, exp_start);
    chk("busy", busy, exp_busy);
    chk("pairs_loaded", pairs_loaded, exp_pairs);
    chk("state", dbg_state, exp_state);
  endtask

  // Driver: one clock cycle with the given inputs, then scoreboard/control checks.
  task automatic step(input logic v, input logic [N-1:0] d, input logic fl,
                      input logic rl, input logic re, input logic [K:0] ra);
    logic [2*N-1:0] e;
    in_valid = v; in_data = d; flush = fl; frm_release = rl; inpRAMen = re; addr = ra;
    if (re) exp_q.push_back(exp_mem[ra]);
    if (v && in_ready && !fl) dut_acc++;
    exp_start = 1'b0;
    if (fl) begin
      exp_state = 2'd0; exp_wp = '0; exp_pairs = '0; exp_busy = 1'b0;
    end else begin
      case (exp_state)
        2'd0: if (v) begin
          if (exp_wp[0]) begin
            exp_mem[exp_wp[4:1]][31:16] = d;
            exp_pairs++;
          end else begin
            exp_mem[exp_wp[4:1]][15:0] = d;
          end
          if (exp_wp == 5'd31) begin
            exp_state = 2'd1; exp_start = 1'b1; exp_busy = 1'b1;
          end
          exp_wp++;
        end
        2'd1: exp_state = 2'd2;
        default: if (rl) begin
          exp_state = 2'd0; exp_pairs = '0; exp_busy = 1'b0;
        end
      endcase
    end
    @(posedge clk);
    #1;
    if (re) begin
      e = exp_q.pop_front();
      chk("rd_a", a, e[15:0]);
      chk("rd_b", b, e[31:16]);
    end
    chk_ctrl();
  endtask

  task automatic idle();
    step(1'b0, '0, 1'b0, 1'b0, 1'b0, '0);
  endtask

  initial begin
    int acc0;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0;
    frm_release = 1'b0; inpRAMen = 1'b0; addr = '0;
    model_reset();
    #17;
    rst = 1'b1;
    #1;
    chk("reset_a", a, 16'h0);
    chk("reset_b", b, 16'h0);
    chk_ctrl();

    // Full frame 0x0001..0x0020 back-to-back
    for (int i = 1; i <= 32; i++) step(1'b1, N'(i), 1'b0, 1'b0, 1'b0, '0);
    chk("frame1_start", start, 1'b1);
    chk("frame1_pairs", pairs_loaded, 5'd16);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd5);
    chk("frame1_a5", a, 16'h000B);
    chk("frame1_b5", b, 16'h000C);
    chk("frame1_start_gone", start, 1'b0);

    // HOLD: offered word must not be taken, storage unchanged
    acc0 = dut_acc;
    for (int i = 0; i < 3; i++) step(1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, '0);
    chk("hold_no_accept", dut_acc - acc0, 0);
    for (int i = 0; i < 16; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, K'(i));

    // Release and refill; a release in FILL must not disturb wp
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 3; i++) step(1'b1, 16'h1000 + N'(i), 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    for (int i = 3; i < 32; i++) step(1'b1, 16'h1000 + N'(i), 1'b0, 1'b0, 1'b0, '0);
    chk("frame2_start", start, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd0);
    chk("frame2_a0", a, 16'h1000);
    chk("frame2_b0", b, 16'h1001);

    // Backpressure: valid toggles, 32 accepts over 63 cycles
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    acc0 = dut_acc;
    for (int i = 0; i < 63; i++)
      step((i % 2) == 0, N'($urandom_range(0, 16'hFFFF)), 1'b0, 1'b0, 1'b0, '0);
    chk("bp_accepts", dut_acc - acc0, 32);
    chk("bp_start", start, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b1, K'($urandom_range(0, 15)));

    // Flush after 7 words drops the concurrent word and restarts the frame
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 7; i++) step(1'b1, 16'h3000 + N'(i), 1'b0, 1'b0, 1'b0, '0);
    acc0 = dut_acc;
    step(1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0, '0);
    chk("flush_dropped", dut_acc - acc0, 0);
    chk("flush_pairs", pairs_loaded, 5'd0);
    for (int i = 0; i < 32; i++) step(1'b1, 16'h2000 + N'(i), 1'b0, 1'b0, 1'b0, '0);
    chk("flush_frame_start", start, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd0);
    chk("flush_a0", a, 16'h2000);
    chk("flush_b0", b, 16'h2001);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd3);

    // Async reset mid-stream, between clock edges
    step(1'b0, '0, 1'b0, 1'b1, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b1, 16'h4000 + N'(i), 1'b0, 1'b0, 1'b0, '0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd0);
    inpRAMen = 1'b0; in_valid = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    model_reset();
    chk("arst_a", a, 16'h0);
    chk("arst_b", b, 16'h0);
    chk_ctrl();
    #3;
    rst = 1'b1;

    // Read-before-write on pair 2 right after reset
    for (int i = 0; i < 4; i++) step(1'b1, 16'h6000 + N'(i), 1'b0, 1'b0, 1'b0, '0);
    step(1'b1, 16'h5555, 1'b0, 1'b0, 1'b1, 4'd2);
    chk("rbw_old_a", a, 16'h0);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd2);
    chk("rbw_new_a", a, 16'h5555);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1, 4'd5);
    chk("arst_storage_cleared", a, 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
